// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one tx_uart among NUM_REQ byte requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 4,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_dv,
    output logic [7:0]           tx_data,
    input  logic                 tx_active,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id,
    output logic                 done,
    output logic                 err
);

    localparam int TMR_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [TMR_W-1:0] timer;

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   idx;
    logic [ID_W-1:0] ptr_next;

    // Scan from ptr upward with wrap; the first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    assign ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESYNC;
            ptr     <= '0;
            timer   <= '0;
            grant   <= '0;
            tx_dv   <= 1'b0;
            tx_data <= '0;
            cur_id  <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
        end else begin
            grant <= '0;
            tx_dv <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                // tx_uart has no reset, so a frame may still be on the line.
                RESYNC: begin
                    if (!tx_active) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (win_found) begin
                        grant   <= NUM_REQ'(1) << win_id;
                        tx_data <= req_data[{win_id, 3'b000} +: 8];
                        tx_dv   <= 1'b1;
                        cur_id  <= win_id;
                        ptr     <= ptr_next;
                        timer   <= '0;
                        state   <= WAIT_START;
                        busy    <= 1'b1;
                    end
                end
                WAIT_START: begin
                    if (tx_active) begin
                        state <= WAIT_DONE;
                    end else if (timer == TMR_W'(START_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_active) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RESYNC;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
